// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and hex-pattern lookup for the 7-segment scan decoder.
package seg_pkg;

    localparam int         SEG_DP    = 7;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] SEG_RESET = 8'h00;

    // Active-low {g,f,e,d,c,b,a} drive for hex digits 0..F.
    localparam logic [6:0] HEX_PAT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        S_WAIT,
        S_QUAL,
        S_HELD
    } state_t;

    // Returns {ok, value}; ok=0 when the pattern matches no hex glyph.
    function automatic logic [4:0] seg_to_hex(input logic [6:0] pat);
        logic [4:0] r;
        r = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (pat == HEX_PAT[i]) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern classifier: hex value, blank, or undecodable.
module seg7_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic       ok_o,
    output logic       blank_o,
    output logic [3:0] val_o
);

    logic [4:0] hex;

    assign hex     = seg_to_hex(pat_i);
    assign ok_o    = hex[4];
    assign val_o   = hex[3:0];
    assign blank_o = (pat_i == SEG_BLANK);

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds eight displayed hex digits from a multiplexed 7-segment bus; commits a digit
// after 1+STABLE_CYCLES cycles of a stable sample, and flags reset frames, bad glyphs and scan stalls.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES   = 200000,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic        i_sclk,
    input  logic        i_reset_n,
    input  logic [7:0]  i_segments,
    input  logic [7:0]  i_digits,
    output logic [31:0] o_digit_vals,
    output logic [7:0]  o_dp,
    output logic [7:0]  o_blank,
    output logic [7:0]  o_valid_mask,
    output logic        o_frame_done,
    output logic        o_bad_pattern,
    output logic        o_reset_seen,
    output logic        o_stalled
);

    localparam int              SW          = $clog2(STABLE_CYCLES + 1);
    localparam int              TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0]   STABLE_MAX  = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0]   TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [7:0]      DIG_IDLE    = DIGIT_ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [7:0]    seg_q, dig_q, held_seg_q, held_seg_d, held_dig_q, held_dig_d;
    state_t        state_q, state_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   vals_q, vals_d;
    logic [7:0]    dp_q, dp_d, blank_q, blank_d, mask_q, mask_d;
    logic          frame_q, frame_d, bad_q, bad_d, rst_seen_q, rst_seen_d;

    logic [7:0] dig_norm;
    logic [2:0] cand_idx;
    logic       cand_ok, cand_rst, cand_any, same, commit;
    logic       dec_ok, dec_blank;
    logic [3:0] dec_val;

    assign dig_norm = DIGIT_ACTIVE_LOW ? ~dig_q : dig_q;
    assign cand_ok  = (dig_norm != 8'h00) && ((dig_norm & (dig_norm - 8'd1)) == 8'h00);
    assign cand_rst = (dig_q == 8'h00) && (seg_q == SEG_RESET);
    assign cand_any = cand_ok || cand_rst;
    assign same     = ({seg_q, dig_q} == {held_seg_q, held_dig_q});

    always_comb begin
        cand_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (dig_norm[i]) cand_idx = 3'(i);
        end
    end

    seg7_pattern_decode u_dec (
        .pat_i   (seg_q[6:0]),
        .ok_o    (dec_ok),
        .blank_o (dec_blank),
        .val_o   (dec_val)
    );

    // A changed sample in S_QUAL or S_HELD is re-evaluated immediately, as if from S_WAIT.
    always_comb begin
        state_d    = state_q;
        held_seg_d = held_seg_q;
        held_dig_d = held_dig_q;
        stab_d     = stab_q;
        commit     = 1'b0;
        if (state_q == S_QUAL && same) begin
            if (stab_q + SW'(1) == STABLE_MAX) begin
                commit  = 1'b1;
                state_d = S_HELD;
                stab_d  = '0;
            end else begin
                stab_d = stab_q + SW'(1);
            end
        end else if (state_q == S_WAIT || !same) begin
            if (cand_any) begin
                state_d    = S_QUAL;
                held_seg_d = seg_q;
                held_dig_d = dig_q;
                stab_d     = SW'(1);
            end else begin
                state_d = S_WAIT;
                stab_d  = '0;
            end
        end
    end

    always_comb begin
        vals_d     = vals_q;
        dp_d       = dp_q;
        blank_d    = blank_q;
        mask_d     = frame_q ? 8'h00 : mask_q;
        frame_d    = 1'b0;
        bad_d      = 1'b0;
        rst_seen_d = 1'b0;
        if (commit && cand_rst) begin
            vals_d     = '0;
            dp_d       = '0;
            blank_d    = '0;
            mask_d     = '0;
            rst_seen_d = 1'b1;
        end else if (commit) begin
            dp_d[cand_idx]    = ~seg_q[SEG_DP];
            blank_d[cand_idx] = dec_blank;
            if (dec_ok) begin
                vals_d[{cand_idx, 2'b00} +: 4] = dec_val;
            end else if (!dec_blank) begin
                bad_d = 1'b1;
            end
            mask_d[cand_idx] = 1'b1;
            frame_d = (mask_d == 8'hFF) && (mask_q != 8'hFF);
        end
    end

    always_comb begin
        if (cand_any) begin
            tmo_d = '0;
        end else if (tmo_q == TIMEOUT_MAX) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // Input registers reset to an idle bus so no phantom reset frame is seen after reset.
    always_ff @(posedge i_sclk) begin
        if (!i_reset_n) begin
            seg_q      <= 8'hFF;
            dig_q      <= DIG_IDLE;
            held_seg_q <= '0;
            held_dig_q <= '0;
            state_q    <= S_WAIT;
            stab_q     <= '0;
            tmo_q      <= '0;
            vals_q     <= '0;
            dp_q       <= '0;
            blank_q    <= '0;
            mask_q     <= '0;
            frame_q    <= 1'b0;
            bad_q      <= 1'b0;
            rst_seen_q <= 1'b0;
        end else begin
            seg_q      <= i_segments;
            dig_q      <= i_digits;
            held_seg_q <= held_seg_d;
            held_dig_q <= held_dig_d;
            state_q    <= state_d;
            stab_q     <= stab_d;
            tmo_q      <= tmo_d;
            vals_q     <= vals_d;
            dp_q       <= dp_d;
            blank_q    <= blank_d;
            mask_q     <= mask_d;
            frame_q    <= frame_d;
            bad_q      <= bad_d;
            rst_seen_q <= rst_seen_d;
        end
    end

    assign o_digit_vals  = vals_q;
    assign o_dp          = dp_q;
    assign o_blank       = blank_q;
    assign o_valid_mask  = mask_q;
    assign o_frame_done  = frame_q;
    assign o_bad_pattern = bad_q;
    assign o_reset_seen  = rst_seen_q;
    assign o_stalled     = (tmo_q == TIMEOUT_MAX);

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: vector table for the digit scan plus hand sequences
// for latency, glitch rejection, bad/blank glyphs, reset frame, timeout and mid-qualify reset.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg, dig;
    logic [31:0] vals;
    logic [7:0]  dp, blank, mask;
    logic        frame_done, bad, rst_seen, stalled;

    int n_pass = 0, n_total = 0;
    int cnt_frame = 0, cnt_bad = 0, cnt_rst = 0;

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .STABLE_CYCLES    (4),
        .TIMEOUT_CYCLES   (40),
        .DIGIT_ACTIVE_LOW (1'b1)
    ) dut (
        .i_sclk        (clk),
        .i_reset_n     (rst_n),
        .i_segments    (seg),
        .i_digits      (dig),
        .o_digit_vals  (vals),
        .o_dp          (dp),
        .o_blank       (blank),
        .o_valid_mask  (mask),
        .o_frame_done  (frame_done),
        .o_bad_pattern (bad),
        .o_reset_seen  (rst_seen),
        .o_stalled     (stalled)
    );

    always @(negedge clk) begin
        if (frame_done) cnt_frame++;
        if (bad)        cnt_bad++;
        if (rst_seen)   cnt_rst++;
    end

    typedef struct {
        logic [7:0]  seg;
        logic [7:0]  dig;
        int          hold;
        logic [31:0] vals;
        logic [7:0]  mask;
        logic [7:0]  dp;
    } vec_t;

    vec_t vt [7];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] s, input logic [7:0] d);
        seg = s;
        dig = d;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    initial begin
        vt[0] = '{8'hC0, 8'hFE, 8, 32'h0000_0000, 8'h01, 8'h00};
        vt[1] = '{8'hF9, 8'hFD, 8, 32'h0000_0010, 8'h03, 8'h00};
        vt[2] = '{8'h24, 8'hFB, 8, 32'h0000_0210, 8'h07, 8'h04};
        vt[3] = '{8'hB0, 8'hF7, 8, 32'h0000_3210, 8'h0F, 8'h04};
        vt[4] = '{8'h99, 8'hEF, 8, 32'h0004_3210, 8'h1F, 8'h04};
        vt[5] = '{8'h92, 8'hDF, 8, 32'h0054_3210, 8'h3F, 8'h04};
        vt[6] = '{8'h82, 8'hBF, 8, 32'h0654_3210, 8'h7F, 8'h04};

        rst_n = 1'b0;
        drive(8'hFF, 8'hFF);
        cyc(3);
        chk("reset_vals",   vals, 32'h0);
        chk("reset_mask",   {24'h0, mask}, 32'h0);
        chk("reset_dp_blk", {16'h0, dp, blank}, 32'h0);
        chk("reset_flags",  {28'h0, frame_done, bad, rst_seen, stalled}, 32'h0);

        // First commit lands exactly 1+STABLE_CYCLES edges after the input change.
        rst_n = 1'b1;
        drive(8'hF9, 8'hFE);
        cyc(4);
        chk("latency_early_mask", {24'h0, mask}, 32'h00);
        cyc(1);
        chk("latency_mask", {24'h0, mask}, 32'h01);
        chk("latency_val",  vals, 32'h0000_0001);
        cyc(5);

        for (int i = 0; i < 7; i++) begin
            drive(vt[i].seg, vt[i].dig);
            cyc(vt[i].hold);
            chk($sformatf("scan%0d_vals", i), vals, vt[i].vals);
            chk($sformatf("scan%0d_mask", i), {24'h0, mask}, {24'h0, vt[i].mask});
            chk($sformatf("scan%0d_dp", i),   {24'h0, dp},   {24'h0, vt[i].dp});
        end

        drive(8'hF8, 8'h7F);
        cyc(5);
        chk("frame_pulse", {31'h0, frame_done}, 32'h1);
        chk("frame_mask",  {24'h0, mask}, 32'hFF);
        chk("frame_vals",  vals, 32'h7654_3210);
        cyc(1);
        chk("frame_pulse_end", {31'h0, frame_done}, 32'h0);
        chk("frame_mask_clr",  {24'h0, mask}, 32'h00);
        cyc(2);

        for (int k = 0; k < 6; k++) begin
            drive((k % 2 == 0) ? 8'hA4 : 8'h99, 8'hFB);
            cyc(2);
        end
        chk("glitch_mask", {24'h0, mask}, 32'h00);
        chk("glitch_vals", vals, 32'h7654_3210);
        drive(8'h92, 8'hFB);
        cyc(8);
        chk("hold5_vals", vals, 32'h7654_3510);
        chk("hold5_dp",   {24'h0, dp}, 32'h00);
        chk("hold5_mask", {24'h0, mask}, 32'h04);

        drive(8'hB6, 8'hFD);
        cyc(5);
        chk("bad_pulse", {31'h0, bad}, 32'h1);
        chk("bad_vals",  vals, 32'h7654_3510);
        chk("bad_mask",  {24'h0, mask}, 32'h06);
        cyc(1);
        chk("bad_pulse_end", {31'h0, bad}, 32'h0);
        drive(8'hFF, 8'hFD);
        cyc(6);
        chk("blank_bits", {24'h0, blank}, 32'h02);
        chk("blank_vals", vals, 32'h7654_3510);

        drive(8'h00, 8'h00);
        cyc(5);
        chk("rstf_pulse", {31'h0, rst_seen}, 32'h1);
        chk("rstf_vals",  vals, 32'h0);
        chk("rstf_rest",  {8'h0, mask, dp, blank}, 32'h0);
        cyc(1);
        chk("rstf_pulse_end", {31'h0, rst_seen}, 32'h0);

        drive(8'hF9, 8'hFC);
        cyc(40);
        chk("stall_pre",  {31'h0, stalled}, 32'h0);
        cyc(1);
        chk("stall_set",  {31'h0, stalled}, 32'h1);
        cyc(9);
        chk("stall_sat",  {31'h0, stalled}, 32'h1);
        drive(8'hF9, 8'hFE);
        cyc(1);
        chk("stall_hold", {31'h0, stalled}, 32'h1);
        cyc(1);
        chk("stall_clr",  {31'h0, stalled}, 32'h0);
        cyc(3);
        chk("recommit_mask", {24'h0, mask}, 32'h01);
        chk("recommit_vals", vals, 32'h0000_0001);

        drive(8'hF9, 8'hFD);
        cyc(2);
        rst_n = 1'b0;
        cyc(1);
        chk("midrst_vals", vals, 32'h0);
        chk("midrst_rest", {8'h0, mask, dp, blank}, 32'h0);
        chk("midrst_flag", {28'h0, frame_done, bad, rst_seen, stalled}, 32'h0);
        rst_n = 1'b1;
        drive(8'hFF, 8'hFF);
        cyc(10);
        chk("postrst_mask", {24'h0, mask}, 32'h0);
        chk("postrst_vals", vals, 32'h0);

        chk("total_frames", cnt_frame, 1);
        chk("total_bad",    cnt_bad,   1);
        chk("total_rstf",   cnt_rst,   1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
